multicycle_control: RTL and testbench

- Parametrised multi-cycle control unit for the MIPS datapath.
- Replaces the single-cycle opcode decoder with a Moore/Mealy FSM that sequences each instruction over 3–5 cycles: fetch, decode, execute, memory, writeback.
- Adds a memory-ready handshake with timeout, an illegal-opcode trap and a state-visibility port.
- Sits between the instruction register opcode field and the datapath muxes/enables; drives ALU control via alu_op.

---
 rtl/multicycle_control.sv | 175 +++++++++++++++++
 tb/tb_multicycle_control.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing
// with a memory-ready wait counter, timeout trap and sticky illegal flag.
module multicycle_control #(
  parameter int OPCODE_W = 6,
  parameter int ALU_OP_W = 2,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                ext_zero,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          pc_source,
  output logic                illegal,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_EXEC_I   = 4'd11,
    S_I_WB     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_R   = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW  = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW  = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_J   = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_ORI = OPCODE_W'(6'b001101);
  localparam logic [OPCODE_W-1:0] OP_LUI = OPCODE_W'(6'b001111);
  localparam logic [CNT_W-1:0]    CNT_TO = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_zero      = 1'b0;
    alu_op        = '0;
    pc_source     = 2'b00;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC load only in the cycle memory actually delivers
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (cnt_q == CNT_TO) begin
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (opcode == OP_R)                         state_d = S_EXEC_R;
        else if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEM_ADDR;
        else if (opcode == OP_BEQ)                  state_d = S_BRANCH;
        else if (opcode == OP_J)                    state_d = S_JUMP;
        else if (opcode == OP_ORI || opcode == OP_LUI) state_d = S_EXEC_I;
        else                                        state_d = S_TRAP;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD, S_MEM_WR: begin
        i_or_d    = 1'b1;
        mem_read  = (state_q == S_MEM_RD);
        mem_write = (state_q == S_MEM_WR);
        if (mem_ready)             state_d = (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
        else if (cnt_q == CNT_TO)  state_d = S_TRAP;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_W'(2'b10);
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_OP_W'(2'b01);
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_OP_W'(2'b11);
        ext_zero  = (opcode == OP_ORI);
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table of per-cycle stimulus/expected state with a
// scoreboard queue, plus hand sequences for reset abort, traps and timeout edges.
module tb_multicycle_control;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic       clk, rst, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, ext_zero, illegal;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
    .alu_op(alu_op), .pc_source(pc_source), .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic       mr;
    logic [3:0] st;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [17:0] ctrl;
    int          idx;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  wire [17:0] act_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                          ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                          alu_src_b, ext_zero, alu_op, pc_source, illegal};

  // Expected control word per state, written from the state descriptions
  function automatic logic [17:0] exp_ctrl(logic [3:0] st, logic mr, logic [5:0] op);
    logic pw, pwc, iod, mrd, mw, irw, m2r, rd, rw, asa, ez, ill;
    logic [1:0] asb, aop, ps;
    {pw, pwc, iod, mrd, mw, irw, m2r, rd, rw, asa, ez, ill} = '0;
    asb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (st)
      4'd1:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      4'd2:  asb = 2'b11;
      4'd3:  begin asa = 1; asb = 2'b10; end
      4'd4:  begin mrd = 1; iod = 1; end
      4'd5:  begin rw = 1; m2r = 1; end
      4'd6:  begin mw = 1; iod = 1; end
      4'd7:  begin asa = 1; aop = 2'b10; end
      4'd8:  begin rw = 1; rd = 1; end
      4'd9:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
      4'd10: begin pw = 1; ps = 2'b10; end
      4'd11: begin asa = 1; asb = 2'b10; aop = 2'b11; ez = (op == OP_ORI); end
      4'd12: rw = 1;
      4'd13: ill = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mw, irw, m2r, rd, rw, asa, asb, ez, aop, ps, ill};
  endfunction

  task automatic chk(string name, logic [17:0] act, logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Called at posedge+1: drive inputs, queue expectation, compare at negedge
  task automatic cycle(logic [5:0] op, logic mr, logic [3:0] st);
    exp_t e;
    opcode = op;
    mem_ready = mr;
    sb.push_back('{st: st, ctrl: exp_ctrl(st, mr, op), idx: cyc});
    @(negedge clk);
    e = sb.pop_front();
    chk("state", {14'd0, state}, {14'd0, e.st});
    chk("ctrl", act_ctrl, e.ctrl);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic add(logic [5:0] op, logic mr, logic [3:0] st);
    tbl.push_back('{op: op, mr: mr, st: st});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; opcode = '0; mem_ready = 1'b0;
    #3;
    chk("reset_state", {14'd0, state}, 18'd0);
    chk("reset_ctrl", act_ctrl, 18'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    add(OP_R, 1, 0);
    add(OP_R, 0, 1); add(OP_R, 0, 1); add(OP_R, 1, 1); add(OP_R, 1, 2);
    add(OP_R, 1, 7); add(OP_R, 1, 8);
    add(OP_LW, 1, 1); add(OP_LW, 1, 2); add(OP_LW, 1, 3);
    add(OP_LW, 0, 4); add(OP_LW, 0, 4); add(OP_LW, 0, 4); add(OP_LW, 1, 4);
    add(OP_LW, 1, 5);
    add(OP_SW, 1, 1); add(OP_SW, 1, 2); add(OP_SW, 1, 3);
    add(OP_SW, 0, 6); add(OP_SW, 1, 6);
    add(OP_BEQ, 1, 1); add(OP_BEQ, 1, 2); add(OP_BEQ, 1, 9);
    add(OP_J, 1, 1); add(OP_J, 1, 2); add(OP_J, 1, 10);
    add(OP_ORI, 1, 1); add(OP_ORI, 1, 2); add(OP_ORI, 1, 11); add(OP_ORI, 1, 12);
    add(OP_LUI, 1, 1); add(OP_LUI, 1, 2); add(OP_LUI, 1, 11); add(OP_LUI, 1, 12);
    add(OP_R, 1, 1);
    foreach (tbl[i]) cycle(tbl[i].op, tbl[i].mr, tbl[i].st);

    // reset asserted mid-EXEC_R aborts before the next edge
    do_reset();
    cycle(OP_R, 1, 0); cycle(OP_R, 1, 1); cycle(OP_R, 1, 2);
    chk("in_exec_r", {14'd0, state}, 18'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state", {14'd0, state}, 18'd0);
    chk("async_rst_ctrl", act_ctrl, 18'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(OP_R, 1, 0); cycle(OP_R, 1, 1);

    // illegal opcode: sticky trap
    do_reset();
    cycle(OP_BAD, 1, 0); cycle(OP_BAD, 1, 1); cycle(OP_BAD, 1, 2);
    for (int i = 0; i < 20; i++)
      cycle(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 13);

    // FETCH timeout: low through count 15 traps
    do_reset();
    cycle(OP_R, 0, 0);
    for (int i = 0; i < 16; i++) cycle(OP_R, 0, 1);
    cycle(OP_R, 1, 13); cycle(OP_R, 1, 13);

    // mem_ready exactly at count 15 succeeds
    do_reset();
    cycle(OP_R, 0, 0);
    for (int i = 0; i < 15; i++) cycle(OP_R, 0, 1);
    cycle(OP_R, 1, 1); cycle(OP_R, 1, 2); cycle(OP_R, 1, 7);

    // MEM_RD timeout, counter restarted on entry
    do_reset();
    cycle(OP_LW, 0, 0);
    for (int i = 0; i < 10; i++) cycle(OP_LW, 0, 1);
    cycle(OP_LW, 1, 1); cycle(OP_LW, 1, 2); cycle(OP_LW, 1, 3);
    for (int i = 0; i < 16; i++) cycle(OP_LW, 0, 4);
    cycle(OP_LW, 1, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
